cnt_spi_readout: RTL and testbench

//  Downstream of freq_cnt_calc: snapshots stand_cnt/test_cnt on each calc_flag and serves them to an external host

---
 rtl/cnt_spi_readout.sv | 224 ++++++++++++++++++++++
 tb/tb_cnt_spi_readout.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cnt_spi_readout.sv
// Snapshots freq_cnt_calc results and serves them to a host over a CS-less SPI mode-0 slave.
// Build option: define SPI_CRC8_EN to append a CRC-8 (poly 0x07) after the 72-bit response word.
module cnt_spi_readout #(
    parameter int         CNT_W    = 34,
    parameter logic [7:0] CMD_READ = 8'hA5,
    parameter int         IDLE_TO  = 1024
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [CNT_W-1:0] stand_cnt,
    input  logic [CNT_W-1:0] test_cnt,
    input  logic             calc_flag,
    input  logic             spi_clk,
    input  logic             spi_mosi,
    output logic             miso,
    output logic             busy
);

    localparam int WORD_W = 2 * CNT_W + 4;
`ifdef SPI_CRC8_EN
    localparam int CRC_W = 8;
`else
    localparam int CRC_W = 0;
`endif
    localparam int SR_W       = WORD_W + CRC_W;
    localparam int FRAME_BITS = 8 + SR_W;
    localparam int BC_W       = $clog2(FRAME_BITS + 1);
    localparam int TO_W       = $clog2(IDLE_TO + 1);

    typedef enum logic [1:0] {IDLE, CMD, RESP, DUMMY} state_t;

    state_t           state, state_nx;
    logic [2:0]       sclk_q;
    logic [1:0]       mosi_q;
    logic             sclk_rise, sclk_fall, mosi_s;
    logic [TO_W-1:0]  to_cnt;
    logic             timeout;
    logic [BC_W-1:0]  bit_cnt;
    logic [6:0]       cmd_sr;
    logic             cmd_match;
    logic [SR_W-1:0]  resp_sr;
    logic [SR_W-1:0]  resp_load;
    logic [WORD_W-1:0] resp_word;
    logic             cf_q, cf_rise;
    logic [CNT_W-1:0] shadow_stand, shadow_test, pend_stand, pend_test;
    logic             valid, overrun, pend_full, ovr_since_load;
    logic             last_fall, frame_end, resp_end, load_evt;

    // spi_clk uses a third stage only for edge detection; mosi is aligned with stage 2.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sclk_q <= '0;
            mosi_q <= '0;
            cf_q   <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_clk};
            mosi_q <= {mosi_q[0], spi_mosi};
            cf_q   <= calc_flag;
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign mosi_s    = mosi_q[1];
    assign cf_rise   = calc_flag & ~cf_q;
    assign busy      = (state != IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            to_cnt <= '0;
        else if (state == IDLE || sclk_q[1] || timeout)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TO_W'(1);
    end

    assign timeout   = (state != IDLE) && !sclk_q[1] && (to_cnt == TO_W'(IDLE_TO - 1));
    assign last_fall = sclk_fall && (bit_cnt == BC_W'(FRAME_BITS));
    assign frame_end = timeout || ((state == RESP || state == DUMMY) && last_fall);
    assign resp_end  = !timeout && (state == RESP) && last_fall;
    assign load_evt  = !timeout && (state == CMD) && sclk_fall
                       && (bit_cnt == BC_W'(8)) && cmd_match;

    assign resp_word = {2'b00, valid, overrun, shadow_stand, shadow_test};

`ifdef SPI_CRC8_EN
    function automatic logic [7:0] crc8(input logic [WORD_W-1:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction
    assign resp_load = {resp_word, crc8(resp_word)};
`else
    assign resp_load = resp_word;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (timeout) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:  if (sclk_rise) state_nx = CMD;
                CMD:   if (sclk_fall && bit_cnt == BC_W'(8)) state_nx = cmd_match ? RESP : DUMMY;
                RESP,
                DUMMY: if (last_fall) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Rising edges are counted in every non-idle state; falls move miso.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bit_cnt   <= '0;
            cmd_sr    <= '0;
            cmd_match <= 1'b0;
            resp_sr   <= '0;
            miso      <= 1'b0;
        end else if (timeout) begin
            bit_cnt <= '0;
            miso    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (sclk_rise) begin
                        bit_cnt <= BC_W'(1);
                        cmd_sr  <= {cmd_sr[5:0], mosi_s};
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        bit_cnt <= bit_cnt + BC_W'(1);
                        cmd_sr  <= {cmd_sr[5:0], mosi_s};
                        if (bit_cnt == BC_W'(7))
                            cmd_match <= ({cmd_sr, mosi_s} == CMD_READ);
                    end
                    if (sclk_fall && bit_cnt == BC_W'(8)) begin
                        if (cmd_match) begin
                            miso    <= resp_load[SR_W-1];
                            resp_sr <= {resp_load[SR_W-2:0], 1'b0};
                        end else begin
                            miso <= 1'b0;
                        end
                    end
                end
                RESP: begin
                    if (sclk_rise) bit_cnt <= bit_cnt + BC_W'(1);
                    if (sclk_fall) begin
                        if (last_fall) begin
                            miso    <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            miso    <= resp_sr[SR_W-1];
                            resp_sr <= {resp_sr[SR_W-2:0], 1'b0};
                        end
                    end
                end
                DUMMY: begin
                    miso <= 1'b0;
                    if (sclk_rise) bit_cnt <= bit_cnt + BC_W'(1);
                    if (last_fall) bit_cnt <= '0;
                end
                default: begin
                    miso    <= 1'b0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // ovr_since_load keeps overruns raised after the word was loaded, so the
    // read-to-clear only drops what the host has actually seen.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shadow_stand   <= '0;
            shadow_test    <= '0;
            pend_stand     <= '0;
            pend_test      <= '0;
            valid          <= 1'b0;
            overrun        <= 1'b0;
            pend_full      <= 1'b0;
            ovr_since_load <= 1'b0;
        end else begin
            if (load_evt) ovr_since_load <= 1'b0;
            if (resp_end) overrun <= ovr_since_load;
            if (cf_rise && frame_end) begin
                shadow_stand <= stand_cnt;
                shadow_test  <= test_cnt;
                valid        <= 1'b1;
                pend_full    <= 1'b0;
                if (pend_full) overrun <= 1'b1;
            end else if (cf_rise && busy) begin
                pend_stand <= stand_cnt;
                pend_test  <= test_cnt;
                pend_full  <= 1'b1;
                if (pend_full) begin
                    overrun        <= 1'b1;
                    ovr_since_load <= 1'b1;
                end
            end else if (cf_rise) begin
                shadow_stand <= stand_cnt;
                shadow_test  <= test_cnt;
                valid        <= 1'b1;
            end else if (frame_end && pend_full) begin
                shadow_stand <= pend_stand;
                shadow_test  <= pend_test;
                valid        <= 1'b1;
                pend_full    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cnt_spi_readout.sv
// Directed bench for cnt_spi_readout: host SPI frames driven from tasks, response words scoreboarded.
module tb_cnt_spi_readout;

    localparam int CNT_W   = 34;
    localparam int IDLE_TO = 1024;
    localparam int HALF    = 8;
`ifdef SPI_CRC8_EN
    localparam int FRAME = 88;
`else
    localparam int FRAME = 80;
`endif

    logic             sys_clk = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic [CNT_W-1:0] stand_cnt = '0;
    logic [CNT_W-1:0] test_cnt = '0;
    logic             calc_flag = 1'b0;
    logic             spi_clk = 1'b0;
    logic             spi_mosi = 1'b0;
    logic             miso, busy;

    int vectors = 0;
    int miscompares = 0;
    logic [71:0] exp_q[$];
    logic [CNT_W-1:0] inj_s[2];
    logic [CNT_W-1:0] inj_t[2];
    logic [87:0] rx;

    cnt_spi_readout #(.CNT_W(CNT_W), .CMD_READ(8'hA5), .IDLE_TO(IDLE_TO)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .stand_cnt (stand_cnt),
        .test_cnt  (test_cnt),
        .calc_flag (calc_flag),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .miso      (miso),
        .busy      (busy)
    );

    // Clock / reset
    always #5 sys_clk = ~sys_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [71:0] mk_word(input logic v, input logic o,
                                            input logic [CNT_W-1:0] s, input logic [CNT_W-1:0] t);
        return {2'b00, v, o, s, t};
    endfunction

    function automatic logic [7:0] crc8_ref(input logic [71:0] d);
        logic [7:0] c;
        logic fb;
        c = 8'h00;
        for (int i = 71; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic pulse_calc(input logic [CNT_W-1:0] s, input logic [CNT_W-1:0] t);
        stand_cnt = s;
        test_cnt  = t;
        calc_flag = 1'b1;
        @(negedge sys_clk);
        calc_flag = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic spi_xfer(input logic [7:0] cmd, input int nclk, input int inj_at,
                            input int n_inj, output logic [87:0] rx_o);
        rx_o = '0;
        for (int i = 0; i < nclk; i++) begin
            spi_mosi = (i < 8) ? cmd[7-i] : 1'b0;
            if (i == inj_at)
                for (int k = 0; k < n_inj; k++) pulse_calc(inj_s[k], inj_t[k]);
            repeat (HALF) @(negedge sys_clk);
            rx_o = {rx_o[86:0], miso};
            spi_clk = 1'b1;
            repeat (HALF) @(negedge sys_clk);
            spi_clk = 1'b0;
        end
        repeat (HALF) @(negedge sys_clk);
    endtask

    // Scoreboard: pop the expected word and compare it with a full A5 read.
    task automatic read_and_check(input string tag);
        logic [71:0] exp_w;
        logic [71:0] got_w;
        spi_xfer(8'hA5, FRAME, -1, 0, rx);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s_queue: observed empty queue expected an entry", tag);
        end else begin
            exp_w = exp_q.pop_front();
`ifdef SPI_CRC8_EN
            got_w = rx[79:8];
            check({tag, "_crc"}, {80'd0, rx[7:0]}, {80'd0, crc8_ref(exp_w)});
`else
            got_w = rx[71:0];
`endif
            check({tag, "_word"}, {16'd0, got_w}, {16'd0, exp_w});
        end
        check({tag, "_busy"}, {87'd0, busy}, 88'd0);
    endtask

    localparam logic [CNT_W-1:0] S1 = 34'h0_0000_0001;
    localparam logic [CNT_W-1:0] T1 = 34'h3_FFFF_FFFF;
    localparam logic [CNT_W-1:0] S2A = 34'h0_0000_1234;
    localparam logic [CNT_W-1:0] T2A = 34'h2_0000_5678;
    localparam logic [CNT_W-1:0] S2B = 34'h3_0F0F_0F0F;
    localparam logic [CNT_W-1:0] T2B = 34'h0_ABCD_EF01;
    localparam logic [CNT_W-1:0] S3 = 34'h2_AAAA_5555;
    localparam logic [CNT_W-1:0] T3 = 34'h1_5555_AAAA;

    initial begin
        repeat (3) @(negedge sys_clk);
        check("rst_miso", {87'd0, miso}, 88'd0);
        check("rst_busy", {87'd0, busy}, 88'd0);
        sys_rst_n = 1'b1;
        repeat ($urandom_range(4, 9)) @(negedge sys_clk);

        // Read before any measurement: valid=0, counts 0.
        exp_q.push_back(mk_word(1'b0, 1'b0, '0, '0));
        read_and_check("empty");

        // First measurement loads the shadow directly.
        pulse_calc(S1, T1);
        exp_q.push_back(mk_word(1'b1, 1'b0, S1, T1));
        spi_xfer(8'hA5, FRAME, -1, 0, rx);
`ifdef SPI_CRC8_EN
        check("t1_word", {16'd0, rx[79:8]}, {16'd0, exp_q[0]});
        check("t1_crc", {80'd0, rx[7:0]}, {80'd0, crc8_ref(exp_q[0])});
`else
        check("t1_word", {16'd0, rx[71:0]}, {16'd0, exp_q[0]});
`endif
        void'(exp_q.pop_front());
        check("t1_cmd_phase", {80'd0, rx[FRAME-1 -: 8]}, 88'd0);
        check("t1_busy", {87'd0, busy}, 88'd0);

        // Unknown command: miso stays 0 for the whole frame.
        spi_xfer(8'h3C, FRAME, -1, 0, rx);
        check("dummy_rx", rx, 88'd0);
        check("dummy_busy", {87'd0, busy}, 88'd0);

        // Two measurements land mid-response: frame keeps the old shadow.
        inj_s[0] = S2A; inj_t[0] = T2A;
        inj_s[1] = S2B; inj_t[1] = T2B;
        exp_q.push_back(mk_word(1'b1, 1'b0, S1, T1));
        spi_xfer(8'hA5, FRAME, 20, 2, rx);
`ifdef SPI_CRC8_EN
        check("ovr_f1_word", {16'd0, rx[79:8]}, {16'd0, exp_q.pop_front()});
`else
        check("ovr_f1_word", {16'd0, rx[71:0]}, {16'd0, exp_q.pop_front()});
`endif
        check("ovr_f1_busy", {87'd0, busy}, 88'd0);
        // A dummy frame in between must not clear the overrun.
        spi_xfer(8'h00, FRAME, -1, 0, rx);
        check("ovr_dummy_rx", rx, 88'd0);
        exp_q.push_back(mk_word(1'b1, 1'b1, S2B, T2B));
        read_and_check("ovr_f2");
        exp_q.push_back(mk_word(1'b1, 1'b0, S2B, T2B));
        read_and_check("ovr_f3");

        // Abandoned frame with a pending measurement, recovered by the idle timeout.
        inj_s[0] = S3; inj_t[0] = T3;
        spi_xfer(8'hA5, 20, 12, 1, rx);
        check("to_busy_mid", {87'd0, busy}, 88'd1);
        repeat (IDLE_TO + 5) @(negedge sys_clk);
        check("to_busy_after", {87'd0, busy}, 88'd0);
        check("to_miso_after", {87'd0, miso}, 88'd0);
        exp_q.push_back(mk_word(1'b1, 1'b0, S3, T3));
        read_and_check("to_fresh");

        // Async reset mid-frame returns to idle immediately.
        spi_xfer(8'hA5, 12, -1, 0, rx);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("rst_mid_busy", {87'd0, busy}, 88'd0);
        check("rst_mid_miso", {87'd0, miso}, 88'd0);
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        exp_q.push_back(mk_word(1'b0, 1'b0, '0, '0));
        read_and_check("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
